// File: rtl/fetch_align_unit.sv
// fetch_align_unit: RV32IC fetch front end over a dual-port halfword memory, one instruction per handshake.
module fetch_align_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr1,
  output logic [31:0] mem_addr2,
  output logic        mem_renable,
  input  logic [15:0] mem_rdata1,
  input  logic [15:0] mem_rdata2,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_is_rvc
);
  typedef enum logic {S_BOOT, S_RUN} state_t;
  state_t      state_q;
  logic [31:0] fetch_pc_q, fetch_pc_d, redir_pc, next_pc;
  logic        resp_valid_q, resp_valid_d, run, rvc, advance;
  always_comb begin
    run          = state_q == S_RUN;
    redir_pc     = redirect_pc & ~32'h1;
    rvc          = mem_rdata1[1:0] != 2'b11;
    next_pc      = fetch_pc_q + (rvc ? 32'd2 : 32'd4);
    instr_valid  = ~rst & run & resp_valid_q & ~redirect_valid;
    advance      = instr_valid & instr_ready;
    instr_is_rvc = ~rst & run & rvc;
    instr        = (rst | ~run) ? 32'h0 : rvc ? {16'h0, mem_rdata1} : {mem_rdata2, mem_rdata1};
    instr_pc     = rst ? RESET_PC : fetch_pc_q;
    mem_renable  = ~rst & (~run | ~resp_valid_q | redirect_valid | advance);
    // the next fetch address is issued in the same cycle the current one is consumed
    fetch_pc_d   = redirect_valid ? redir_pc : advance ? next_pc : fetch_pc_q;
    resp_valid_d = resp_valid_q | mem_renable;
    mem_addr1    = rst ? RESET_PC : fetch_pc_d;
    mem_addr2    = mem_addr1 + 32'd2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_BOOT;
      resp_valid_q <= 1'b0;
      fetch_pc_q   <= RESET_PC;
    end else begin
      state_q      <= S_RUN;
      resp_valid_q <= resp_valid_d;
      fetch_pc_q   <= fetch_pc_d;
    end
  end
endmodule

// File: tb/tb_fetch_align_unit.sv
// tb_fetch_align_unit: directed vectors plus randomized run against an instruction-stream model.
module tb_fetch_align_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] mem_addr1, mem_addr2, redirect_pc = 32'h0, instr, instr_pc;
  logic        mem_renable, redirect_valid = 1'b0, instr_valid, instr_ready = 1'b1, instr_is_rvc;
  logic [15:0] mem_rdata1 = 16'h0, mem_rdata2 = 16'h0;
  int          n_cmp = 0, n_bad = 0;

  fetch_align_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
    .mem_renable(mem_renable), .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .instr_is_rvc(instr_is_rvc)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [logic [30:0]];
  function automatic logic [15:0] rd(input logic [31:0] a);
    return mem.exists(a[31:1]) ? mem[a[31:1]] : 16'h0001;
  endfunction
  always @(posedge clk) if (mem_renable) begin
    mem_rdata1 <= rd(mem_addr1);
    mem_rdata2 <= rd(mem_addr2);
  end

  task automatic chk(input string nm, input logic ev, input logic [31:0] epc, ei,
                     input logic ervc, eren, input logic [31:0] ea);
    logic ok;
    ok = instr_valid == ev && mem_renable == eren && mem_addr1 == ea && mem_addr2 == ea + 32'd2 &&
         (!(ev || rst) || (instr_pc == epc && instr == ei && instr_is_rvc == ervc));
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got v=%b ren=%b a1=%h a2=%h pc=%h ins=%h rvc=%b, want v=%b ren=%b a1=%h pc=%h ins=%h rvc=%b",
               nm, instr_valid, mem_renable, mem_addr1, mem_addr2, instr_pc, instr, instr_is_rvc,
               ev, eren, ea, epc, ei, ervc);
    end
  endtask

  task automatic drive(input logic r, rv, input logic [31:0] rp, input logic rdy);
    rst = r; redirect_valid = rv; redirect_pc = rp; instr_ready = rdy;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic r, rv; logic [31:0] rp; logic rdy;
    logic ev; logic [31:0] epc, ei; logic ervc, eren; logic [31:0] ea;
  } vec_t;
  vec_t tbl [18];

  logic        m_boot, r, rv, rdy, ev, ervc, eren, mrvc;
  logic [31:0] m_pc, rp, epc, ei, ea;
  logic [15:0] lo, hi;

  initial begin
    @(posedge clk); #1;
    mem.delete(); mem[0] = 16'h0513; mem[1] = 16'h0000;
    drive(1, 0, 0, 1); chk("a_rst", 0, 0, 0, 0, 0, 0); adv();
    drive(0, 0, 0, 1); chk("a_boot", 0, 0, 0, 0, 1, 0); adv();
    drive(0, 0, 0, 1); chk("a_first", 1, 0, 32'h0000_0513, 0, 1, 4); adv();

    mem.delete();
    mem[0] = 16'h4501; mem[1] = 16'h0593; mem[2] = 16'h00A0; mem[3] = 16'h8082;
    mem[31'h81] = 16'h0001; mem[31'h7FFF_FFFF] = 16'h4505;
    tbl[0]  = '{1, 0, 0, 1,            0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1,            0, 0, 0, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 1,            1, 0, 32'h4501, 1, 1, 2};
    tbl[3]  = '{0, 0, 0, 0,            1, 2, 32'h00A0_0593, 0, 0, 2};
    tbl[4]  = '{0, 0, 0, 0,            1, 2, 32'h00A0_0593, 0, 0, 2};
    tbl[5]  = '{0, 0, 0, 0,            1, 2, 32'h00A0_0593, 0, 0, 2};
    tbl[6]  = '{0, 0, 0, 1,            1, 2, 32'h00A0_0593, 0, 1, 6};
    tbl[7]  = '{0, 1, 32'h103, 1,      0, 0, 0, 0, 1, 32'h102};
    tbl[8]  = '{0, 0, 0, 0,            1, 32'h102, 32'h1, 1, 0, 32'h102};
    tbl[9]  = '{0, 1, 2, 0,            0, 0, 0, 0, 1, 2};
    tbl[10] = '{0, 0, 0, 1,            1, 2, 32'h00A0_0593, 0, 1, 6};
    tbl[11] = '{0, 1, 32'h100, 1,      0, 0, 0, 0, 1, 32'h100};
    tbl[12] = '{0, 1, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFE};
    tbl[13] = '{0, 0, 0, 1,            1, 32'hFFFF_FFFE, 32'h4505, 1, 1, 0};
    tbl[14] = '{0, 0, 0, 0,            1, 0, 32'h4501, 1, 0, 0};
    tbl[15] = '{1, 0, 0, 0,            0, 0, 0, 0, 0, 0};
    tbl[16] = '{0, 0, 0, 1,            0, 0, 0, 0, 1, 0};
    tbl[17] = '{0, 0, 0, 1,            1, 0, 32'h4501, 1, 1, 2};
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].r, tbl[i].rv, tbl[i].rp, tbl[i].rdy);
      chk($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].ei, tbl[i].ervc, tbl[i].eren, tbl[i].ea);
      adv();
    end

    mem.delete();
    for (int a = 0; a < 200; a++) mem[a] = 16'($urandom);
    m_boot = 1'b1; m_pc = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      r   = (i == 0) || ($urandom_range(0, 99) == 0);
      rv  = $urandom_range(0, 9) == 0;
      rp  = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom_range(0, 300));
      rdy = $urandom_range(0, 3) != 0;
      lo = rd(m_pc); hi = rd(m_pc + 32'd2);
      mrvc = lo[1:0] != 2'b11;
      epc = m_pc; ei = mrvc ? {16'h0, lo} : {hi, lo}; ervc = mrvc;
      if (r) begin
        ev = 0; eren = 0; ea = 0; epc = 0; ei = 0; ervc = 0;
      end else if (m_boot) begin
        ev = 0; eren = 1; ea = rv ? (rp & ~32'h1) : m_pc;
      end else begin
        ev = ~rv; eren = rv | rdy;
        ea = rv ? (rp & ~32'h1) : rdy ? m_pc + (mrvc ? 32'd2 : 32'd4) : m_pc;
      end
      drive(r, rv, rp, rdy);
      chk($sformatf("rnd%0d", i), ev, epc, ei, ervc, eren, ea);
      adv();
      m_boot = r;
      m_pc = r ? 32'h0 : ea;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
